// File: rtl/tqvp_fpu_host.sv
// -----------------------------------------------------------------------------
// tqvp_fpu_host
//
// Purpose:
//   Host-side sequencer for a memory-mapped single-precision FPU peripheral.
//   Each accepted command writes operand A, operand B and the opcode to the
//   peripheral. It then polls the status register until the busy bit clears,
//   reads the result and presents it on a valid/ready response port. Every
//   bus transfer is followed by one idle GAP cycle.
//
// Peripheral register map (byte offsets on bus_address):
//   0x00 A, 0x04 B, 0x08 control ({30'b0, op}), 0x0C result, 0x10 status
//   (only bit0, busy, is used).
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op[1:0]                01 add, 10 mul, 11 sub, 00 illegal
//   cmd_a, cmd_b [31:0]        IEEE-754 single operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_data[31:0], rsp_err    FPU result, error (illegal op or timeout)
//   busy                       a command is in progress
//   bus_address[5:0]           register offset (0 when no transfer is active)
//   bus_wdata[31:0]            write data
//   bus_write_n[1:0]           10 word write, 11 idle
//   bus_read_n[1:0]            10 word read, 11 idle
//   bus_rdata[31:0]            read data, captured when bus_ready is sampled 1
//   bus_ready                  peripheral completes the current transfer
//
// Configuration:
//   FPU_HOST_TIMEOUT_EN  When defined, at most POLL_LIMIT status reads are
//                        made per command. After that the command ends with
//                        rsp_err=1 and rsp_data=0. When undefined, polling is
//                        unbounded and no poll counter exists.
// -----------------------------------------------------------------------------
module tqvp_fpu_host #(
  parameter int unsigned POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_A    = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_WR_CTRL = 3'd3;
  localparam logic [2:0] ST_POLL    = 3'd4;
  localparam logic [2:0] ST_RD_RES  = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;
  localparam logic [2:0] ST_GAP     = 3'd7;

  localparam logic [5:0] ADDR_A    = 6'h00;
  localparam logic [5:0] ADDR_B    = 6'h04;
  localparam logic [5:0] ADDR_CTRL = 6'h08;
  localparam logic [5:0] ADDR_RES  = 6'h0C;
  localparam logic [5:0] ADDR_STAT = 6'h10;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] STROBE_ON  = 2'b10;
  localparam logic [1:0] STROBE_OFF = 2'b11;

  logic [2:0]  r_state;
  logic [2:0]  w_state_d;
  // State to enter once the GAP cycle after a transfer has elapsed.
  logic [2:0]  r_after_gap;
  logic [2:0]  w_after_gap_d;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rsp_data;
  logic [31:0] w_rsp_data_d;
  logic        r_rsp_err;
  logic        w_rsp_err_d;
  logic        w_accept;

`ifdef FPU_HOST_TIMEOUT_EN
  // The counter holds the number of completed busy polls so far. It only has
  // to reach POLL_LIMIT-1, because the limit-th busy reply ends polling.
  localparam int unsigned CNT_W = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

  logic [CNT_W-1:0] r_poll_cnt;
  logic [CNT_W-1:0] w_poll_cnt_d;
`else
  // POLL_LIMIT only matters when the timeout is built in.
  logic w_unused_poll_limit;
  assign w_unused_poll_limit = (POLL_LIMIT == 0);
`endif

  assign w_accept = cmd_valid & (r_state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d     = r_state;
    w_after_gap_d = r_after_gap;
    w_rsp_data_d  = r_rsp_data;
    w_rsp_err_d   = r_rsp_err;
`ifdef FPU_HOST_TIMEOUT_EN
    w_poll_cnt_d  = r_poll_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ILLEGAL) begin
            // Rejected without touching the bus.
            w_state_d    = ST_RESP;
            w_rsp_data_d = 32'h0;
            w_rsp_err_d  = 1'b1;
          end else begin
            w_state_d = ST_WR_A;
`ifdef FPU_HOST_TIMEOUT_EN
            w_poll_cnt_d = '0;
`endif
          end
        end
      end

      ST_WR_A: begin
        if (bus_ready) begin
          w_state_d     = ST_GAP;
          w_after_gap_d = ST_WR_B;
        end
      end

      ST_WR_B: begin
        if (bus_ready) begin
          w_state_d     = ST_GAP;
          w_after_gap_d = ST_WR_CTRL;
        end
      end

      ST_WR_CTRL: begin
        if (bus_ready) begin
          w_state_d     = ST_GAP;
          w_after_gap_d = ST_POLL;
        end
      end

      ST_POLL: begin
        if (bus_ready) begin
          w_state_d = ST_GAP;
          if (!bus_rdata[0]) begin
            w_after_gap_d = ST_RD_RES;
          end
`ifdef FPU_HOST_TIMEOUT_EN
          else if (r_poll_cnt == POLL_LAST) begin
            // The last allowed poll still reports busy, so give up.
            w_after_gap_d = ST_RESP;
            w_rsp_data_d  = 32'h0;
            w_rsp_err_d   = 1'b1;
          end else begin
            w_after_gap_d = ST_POLL;
            w_poll_cnt_d  = r_poll_cnt + CNT_W'(1);
          end
`else
          else begin
            w_after_gap_d = ST_POLL;
          end
`endif
        end
      end

      ST_RD_RES: begin
        if (bus_ready) begin
          w_state_d     = ST_GAP;
          w_after_gap_d = ST_RESP;
          w_rsp_data_d  = bus_rdata;
          w_rsp_err_d   = 1'b0;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        w_state_d = r_after_gap;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_after_gap <= ST_IDLE;
      r_rsp_data  <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_after_gap <= w_after_gap_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 2'b00;
      r_a  <= 32'h0;
      r_b  <= 32'h0;
    end else if (w_accept) begin
      r_op <= cmd_op;
      r_a  <= cmd_a;
      r_b  <= cmd_b;
    end
  end

`ifdef FPU_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= w_poll_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Bus outputs are decoded from the registered state only. They therefore
  // stay constant for the whole transfer, whatever bus_ready does, and reset
  // forces them idle without a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_address = 6'h00;
    bus_wdata   = 32'h0;
    bus_write_n = STROBE_OFF;
    bus_read_n  = STROBE_OFF;
    case (r_state)
      ST_WR_A: begin
        bus_address = ADDR_A;
        bus_wdata   = r_a;
        bus_write_n = STROBE_ON;
      end
      ST_WR_B: begin
        bus_address = ADDR_B;
        bus_wdata   = r_b;
        bus_write_n = STROBE_ON;
      end
      ST_WR_CTRL: begin
        bus_address = ADDR_CTRL;
        bus_wdata   = {30'b0, r_op};
        bus_write_n = STROBE_ON;
      end
      ST_POLL: begin
        bus_address = ADDR_STAT;
        bus_read_n  = STROBE_ON;
      end
      ST_RD_RES: begin
        bus_address = ADDR_RES;
        bus_read_n  = STROBE_ON;
      end
      default: begin
        bus_address = 6'h00;
      end
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
